mem_stage: RTL and testbench

Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. Takes the registered EX-MEM bundle (address from the ALU result, store data, load/store function code, write-back pass-throughs), runs a request/grant/response handshake with data memory, formats byte/half/word loads and stores, and stalls the pipeline until the access completes. Results are registered into the MEM-WB pipeline buffer for the write-back stage.

---
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/grant/response bus between mem_stage and data memory
//
// Signals:
//   req    master->slave  memory request, held until gnt
//   addr   master->slave  word-aligned byte address
//   we     master->slave  1 = store
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  load data valid this cycle
//   rdata  slave->master  load data word
interface mem_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: data bus handshake, load/store formatting, stall, MEM-WB register
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses trap instead of issuing).
//
// Ports:
//   clock, reset                 pipeline clock, synchronous active-high reset
//   lsu_enable_ip                EX-MEM entry is a load or store
//   mem_lsu_operator_ip          load/store function code
//   mem_alu_result_ip            byte address / ALU result
//   mem_wdata_ip                 store data
//   mem_wb_mux_ip, mem_write_reg_addr_ip, mem_pc_addr_ip, mem_uimmd_ip  write-back pass-throughs
//   data                         data memory bus (mem_stage_if.master)
//   mem_stall_op                 hold upstream stages and EX-MEM this cycle
//   fw_mem_data_op               combinational ALU result for EX forwarding
//   bus_error_op                 one-cycle pulse on bus timeout abort
//   misaligned_op                one-cycle pulse on misaligned trap (only with MEM_MISALIGN_TRAP_EN)
//   wb_*                         MEM-WB pipeline register
package mem_stage_pkg;
  // bit 3 = store, bit 2 = zero-extend, bits 1:0 = size (0 byte, 1 half, 2 word)
  typedef enum logic [3:0] {
    LSU_LB  = 4'b0000,
    LSU_LH  = 4'b0001,
    LSU_LW  = 4'b0010,
    LSU_LBU = 4'b0100,
    LSU_LHU = 4'b0101,
    LSU_SB  = 4'b1000,
    LSU_SH  = 4'b1001,
    LSU_SW  = 4'b1010
  } load_store_func_code;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_PC    = 2'd2,
    WB_UIMMD = 2'd3
  } write_back_mux_selector;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lsu_enable_ip,
  input  load_store_func_code    mem_lsu_operator_ip,
  input  logic [31:0]            mem_alu_result_ip,
  input  logic [31:0]            mem_wdata_ip,
  input  write_back_mux_selector mem_wb_mux_ip,
  input  logic [4:0]             mem_write_reg_addr_ip,
  input  logic [31:0]            mem_pc_addr_ip,
  input  logic [31:0]            mem_uimmd_ip,
  mem_stage_if.master            data,
  output logic                   mem_stall_op,
  output logic [31:0]            fw_mem_data_op,
  output logic                   bus_error_op,
  output logic [31:0]            wb_alu_result_op,
  output logic [31:0]            wb_load_data_op,
  output logic [31:0]            wb_pc_addr_op,
  output logic [31:0]            wb_uimmd_op,
  output write_back_mux_selector wb_mux_op,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                   misaligned_op,
`endif
  output logic [4:0]             wb_write_reg_addr_op
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam int CW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic [3:0]  op_bits;
  logic        is_store;
  logic        zext;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic        misalign_hit;
  logic        timeout_hit;

  logic        stall;
  logic        abort;
  logic        load_done;
  logic        misaligned;
  logic [31:0] load_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_bits  = mem_lsu_operator_ip;
  assign is_store = op_bits[3];
  assign zext     = op_bits[2];
  assign size     = op_bits[1:0];
  assign lane     = mem_alu_result_ip[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_hit = lsu_enable_ip &&
                        (((size == 2'd1) && lane[0]) || ((size == 2'd2) && (lane != 2'b00)));
`else
  assign misalign_hit = 1'b0;
`endif

  // The counter holds the number of wait-state cycles already spent; together with the
  // cycle that launched the phase, reaching BUS_TIMEOUT-1 here means BUS_TIMEOUT stalled cycles.
  assign timeout_hit = (state_q != S_IDLE) && (cnt_q == CW'(BUS_TIMEOUT - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Cleared on every state change, so each wait phase times out independently.
      if ((state_d == state_q) && (state_q != S_IDLE))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_enable_ip && !misalign_hit) begin
          if (data.gnt)
            state_d = is_store ? S_IDLE : S_RESP;
          else
            state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (timeout_hit)
          state_d = S_IDLE;
        else if (data.gnt)
          state_d = is_store ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (timeout_hit || data.rvalid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    data.req   = 1'b0;
    stall      = 1'b0;
    abort      = 1'b0;
    load_done  = 1'b0;
    misaligned = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (lsu_enable_ip) begin
            if (misalign_hit) begin
              misaligned = 1'b1;
            end else begin
              data.req = 1'b1;
              stall    = !(data.gnt && is_store);
            end
          end
        end
        S_REQ: begin
          // Timeout wins over a same-cycle gnt: the request is withdrawn in that cycle.
          if (timeout_hit) begin
            abort = 1'b1;
          end else begin
            data.req = 1'b1;
            stall    = !(data.gnt && is_store);
          end
        end
        S_RESP: begin
          if (timeout_hit)
            abort = 1'b1;
          else if (data.rvalid)
            load_done = 1'b1;
          else
            stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_stall_op   = stall;
  assign bus_error_op   = abort;
  assign fw_mem_data_op = mem_alu_result_ip;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_op  = misaligned;
`endif

  // ---------------- store formatting ----------------
  // EX-MEM is held while stalled, so these stay stable for the whole request.
  assign data.addr = {mem_alu_result_ip[31:2], 2'b00};
  assign data.we   = is_store;

  always_comb begin
    data.be    = 4'hF;
    data.wdata = mem_wdata_ip;
    unique case (size)
      2'd0: begin
        data.be    = 4'b0001 << lane;
        data.wdata = {4{mem_wdata_ip[7:0]}};
      end
      2'd1: begin
        data.be    = 4'b0011 << {lane[1], 1'b0};
        data.wdata = {2{mem_wdata_ip[15:0]}};
      end
      default: begin
        data.be    = 4'hF;
        data.wdata = mem_wdata_ip;
      end
    endcase
  end

  // ---------------- load formatting ----------------
  always_comb begin
    byte_sel = data.rdata[7:0];
    unique case (lane)
      2'd0: byte_sel = data.rdata[7:0];
      2'd1: byte_sel = data.rdata[15:8];
      2'd2: byte_sel = data.rdata[23:16];
      2'd3: byte_sel = data.rdata[31:24];
      default: byte_sel = data.rdata[7:0];
    endcase
  end

  assign half_sel = lane[1] ? data.rdata[31:16] : data.rdata[15:0];

  always_comb begin
    load_fmt = data.rdata;
    unique case (size)
      2'd0:    load_fmt = zext ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_fmt = zext ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_fmt = data.rdata;
    endcase
  end

  // ---------------- MEM-WB register ----------------
  always_ff @(posedge clock) begin
    if (reset || stall) begin
      // Stalled cycles push a bubble so write-back never sees a half-finished access.
      wb_alu_result_op     <= '0;
      wb_load_data_op      <= '0;
      wb_pc_addr_op        <= '0;
      wb_uimmd_op          <= '0;
      wb_mux_op            <= WB_ALU;
      wb_write_reg_addr_op <= '0;
    end else begin
      wb_alu_result_op     <= mem_alu_result_ip;
      wb_load_data_op      <= load_done ? load_fmt : 32'd0;
      wb_pc_addr_op        <= mem_pc_addr_ip;
      wb_uimmd_op          <= mem_uimmd_ip;
      wb_mux_op            <= mem_wb_mux_ip;
      // Aborted or trapped accesses must not write the register file.
      wb_write_reg_addr_op <= (abort || misaligned) ? 5'd0 : mem_write_reg_addr_ip;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking testbench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int T = 16;

  logic clock;
  logic reset;
  logic lsu_enable;
  load_store_func_code op_in;
  logic [31:0] alu_in, wdata_in, pc_in, uimm_in;
  write_back_mux_selector mux_in;
  logic [4:0] rd_in;

  logic stall, bus_error;
  logic [31:0] fw, wb_alu, wb_load, wb_pc, wb_uimm;
  write_back_mux_selector wb_mux;
  logic [4:0] wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_if bus ();

  mem_stage #(.BUS_TIMEOUT(T)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .lsu_enable_ip         (lsu_enable),
    .mem_lsu_operator_ip   (op_in),
    .mem_alu_result_ip     (alu_in),
    .mem_wdata_ip          (wdata_in),
    .mem_wb_mux_ip         (mux_in),
    .mem_write_reg_addr_ip (rd_in),
    .mem_pc_addr_ip        (pc_in),
    .mem_uimmd_ip          (uimm_in),
    .data                  (bus),
    .mem_stall_op          (stall),
    .fw_mem_data_op        (fw),
    .bus_error_op          (bus_error),
    .wb_alu_result_op      (wb_alu),
    .wb_load_data_op       (wb_load),
    .wb_pc_addr_op         (wb_pc),
    .wb_uimmd_op           (wb_uimm),
    .wb_mux_op             (wb_mux),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned_op         (misaligned),
`endif
    .wb_write_reg_addr_op  (wb_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(load_store_func_code op, logic [31:0] a, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (op)
      LSU_LB:  return (b >= 32'h80)   ? b - 32'h100   : b;
      LSU_LBU: return b;
      LSU_LH:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      LSU_LHU: return h;
      default: return d;
    endcase
  endfunction

  function automatic logic is_store_op(load_store_func_code op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  task automatic ref_store(input load_store_func_code op, input logic [31:0] a, input logic [31:0] w,
                           output logic [3:0] be, output logic [31:0] wd);
    case (op)
      LSU_SB:  begin be = 4'(1 << int'(a[1:0]));     wd = (w & 32'hFF) * 32'h01010101;   end
      LSU_SH:  begin be = 4'(3 << (2 * int'(a[1]))); wd = (w & 32'hFFFF) * 32'h00010001; end
      default: begin be = 4'hF;                      wd = w;                             end
    endcase
  endtask

  // g = cycle (from presentation) at which memory grants; r = cycles from grant to rvalid.
  task automatic ref_model(input logic en, input load_store_func_code op, input logic [31:0] a,
                           input int g, input int r, input logic [31:0] d, input logic [4:0] rd,
                           output int stalls, output int errs, output logic [31:0] ld,
                           output logic [4:0] wrd, output logic req);
    logic mis;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = ((op == LSU_LH || op == LSU_LHU || op == LSU_SH) && a[0]) ||
          ((op == LSU_LW || op == LSU_SW) && (a[1:0] != 2'b00));
`endif
    req = en && !mis;
    if (!en) begin
      stalls = 0; errs = 0; ld = 0; wrd = rd;
    end else if (mis) begin
      stalls = 0; errs = 0; ld = 0; wrd = 0;
    end else if (g >= T) begin
      stalls = T; errs = 1; ld = 0; wrd = 0;
    end else if (is_store_op(op)) begin
      stalls = g; errs = 0; ld = 0; wrd = rd;
    end else if (r >= T) begin
      stalls = g + T; errs = 1; ld = 0; wrd = 0;
    end else begin
      stalls = g + r; errs = 0; ld = ref_load(op, a, d); wrd = rd;
    end
  endtask

  // ---------------- stimulus driver (emulates held EX-MEM and a memory) ----------------
  // Entered and left 1 time unit after a rising edge; on return wb_* holds the op's result.
  task automatic run_op(input logic en, input load_store_func_code op, input logic [31:0] a,
                        input logic [31:0] w, input int g, input int r, input logic [31:0] d,
                        input logic [4:0] rd, input write_back_mux_selector mux,
                        input logic [31:0] pc, input logic [31:0] ui,
                        output int stalls, output int errs, output logic f_req,
                        output logic [31:0] f_addr, output logic f_we, output logic [3:0] f_be,
                        output logic [31:0] f_wdata, output logic bubble_ok, output logic hung);
    int k;
    logic done;
    k = 0; done = 1'b0; stalls = 0; errs = 0; bubble_ok = 1'b1; hung = 1'b0;
    f_req = 1'b0; f_addr = '0; f_we = 1'b0; f_be = '0; f_wdata = '0;
    lsu_enable = en; op_in = op; alu_in = a; wdata_in = w; rd_in = rd;
    mux_in = mux; pc_in = pc; uimm_in = ui;
    while (!done) begin
      bus.gnt    = (k == g);
      bus.rvalid = (k == g + r);
      bus.rdata  = bus.rvalid ? d : $urandom;
      @(negedge clock);
      if (k == 0) begin
        f_req = bus.req; f_addr = bus.addr; f_we = bus.we; f_be = bus.be; f_wdata = bus.wdata;
      end
      if (bus_error) errs++;
      if (k > 0 && (wb_rd != 5'd0 || wb_alu != 32'd0 || wb_pc != 32'd0)) bubble_ok = 1'b0;
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clock); #1;
      k++;
      if (k > 200) begin hung = 1'b1; done = 1'b1; end
    end
    lsu_enable = 1'b0; bus.gnt = 1'b0; bus.rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; lsu_enable = 1'b1; op_in = LSU_LW; alu_in = 32'h5555_0000;
    wdata_in = 32'h1; rd_in = 5'd7; mux_in = WB_LOAD; pc_in = 32'h40; uimm_in = 32'h80;
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (bus_error !== 1'b0) begin n_bad++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
    n_cmp++;
    if ({wb_alu, wb_load, wb_pc, wb_uimm, wb_mux, wb_rd} !== '0) begin
      n_bad++; $display("FAIL reset_wb: got %h %h %h %h %0d %0d want all 0", wb_alu, wb_load, wb_pc, wb_uimm, wb_mux, wb_rd);
    end
    bus.gnt = 1'b0; bus.rvalid = 1'b0; lsu_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    int st, er; logic fr, fw_e, bo, hg; logic [31:0] fa, fwd; logic [3:0] fb;
    run_op(1'b0, LSU_LW, 32'h1234, 32'h0, 0, 1, 32'h0, 5'd3, WB_ALU, 32'h100, 32'h200,
           st, er, fr, fa, fw_e, fb, fwd, bo, hg);
    n_cmp++; if (fr !== 1'b0) begin n_bad++; $display("FAIL alu_req: got %b want 0", fr); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL alu_stalls: got %0d want 0", st); end
    n_cmp++; if (wb_alu !== 32'h1234) begin n_bad++; $display("FAIL alu_wb_result: got %h want 00001234", wb_alu); end
    n_cmp++; if (wb_rd !== 5'd3) begin n_bad++; $display("FAIL alu_wb_rd: got %0d want 3", wb_rd); end
    n_cmp++; if (fw !== 32'h1234) begin n_bad++; $display("FAIL alu_fw: got %h want 00001234", fw); end
  endtask

  task automatic test_store_sb();
    int st, er; logic fr, fw_e, bo, hg; logic [31:0] fa, fwd; logic [3:0] fb;
    run_op(1'b1, LSU_SB, 32'h1003, 32'h0000_00AB, 0, 1, 32'h0, 5'd0, WB_ALU, 32'h0, 32'h0,
           st, er, fr, fa, fw_e, fb, fwd, bo, hg);
    n_cmp++; if (fb !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b want 1000", fb); end
    n_cmp++; if (fwd !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata: got %h want abababab", fwd); end
    n_cmp++; if (fw_e !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b want 1", fw_e); end
    n_cmp++; if (fa !== 32'h1000) begin n_bad++; $display("FAIL sb_addr: got %h want 00001000", fa); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL sb_stalls: got %0d want 0", st); end
  endtask

  task automatic test_load_format();
    load_store_func_code ops[4] = '{LSU_LB, LSU_LBU, LSU_LH, LSU_LHU};
    logic [31:0] rdv[4] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] want[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    int st, er; logic fr, fw_e, bo, hg; logic [31:0] fa, fwd; logic [3:0] fb;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, ops[i], 32'h2002, 32'h0, 2, 1, rdv[i], 5'd9, WB_LOAD, 32'h0, 32'h0,
             st, er, fr, fa, fw_e, fb, fwd, bo, hg);
      n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL load%0d_stalls: got %0d want 3", i, st); end
      n_cmp++; if (wb_load !== want[i]) begin n_bad++; $display("FAIL load%0d_data: got %h want %h", i, wb_load, want[i]); end
      n_cmp++; if (wb_rd !== 5'd9) begin n_bad++; $display("FAIL load%0d_rd: got %0d want 9", i, wb_rd); end
      n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL load%0d_bubble: got %b want 1", i, bo); end
    end
  endtask

  task automatic test_timeout();
    // {is_load, g, r} boundary cases around BUS_TIMEOUT
    int gs[5] = '{1000, T - 1, T,    0,     0};
    int rs[5] = '{1,    1,     1,    T - 1, T};
    load_store_func_code ops[5] = '{LSU_LW, LSU_SW, LSU_SH, LSU_LW, LSU_LW};
    int st, er, xs, xe; logic fr, fw_e, bo, hg, xq; logic [31:0] fa, fwd, xl; logic [3:0] fb; logic [4:0] xr;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, ops[i], 32'h3000, 32'h77, gs[i], rs[i], 32'hCAFE_F00D, 5'd12, WB_LOAD, 32'h4, 32'h8,
             st, er, fr, fa, fw_e, fb, fwd, bo, hg);
      ref_model(1'b1, ops[i], 32'h3000, gs[i], rs[i], 32'hCAFE_F00D, 5'd12, xs, xe, xl, xr, xq);
      n_cmp++; if (hg !== 1'b0) begin n_bad++; $display("FAIL to%0d_hang: op never completed", i); end
      n_cmp++; if (st !== xs) begin n_bad++; $display("FAIL to%0d_stalls: got %0d want %0d", i, st, xs); end
      n_cmp++; if (er !== xe) begin n_bad++; $display("FAIL to%0d_bus_error: got %0d pulses want %0d", i, er, xe); end
      n_cmp++; if (wb_rd !== xr) begin n_bad++; $display("FAIL to%0d_rd: got %0d want %0d", i, wb_rd, xr); end
      if (!is_store_op(ops[i])) begin
        n_cmp++; if (wb_load !== xl) begin n_bad++; $display("FAIL to%0d_data: got %h want %h", i, wb_load, xl); end
      end
      n_cmp++; if (bus_error !== 1'b0) begin n_bad++; $display("FAIL to%0d_pulse_end: got %b want 0", i, bus_error); end
    end
  endtask

  task automatic test_reset_mid_access();
    int st, er; logic fr, fw_e, bo, hg; logic [31:0] fa, fwd; logic [3:0] fb;
    lsu_enable = 1'b1; op_in = LSU_LW; alu_in = 32'h3000; rd_in = 5'd5; mux_in = WB_LOAD;
    pc_in = 32'h10; uimm_in = 32'h20; bus.gnt = 1'b1;
    @(posedge clock); #1;
    bus.gnt = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; lsu_enable = 1'b0; op_in = LSU_LB; alu_in = '0; wdata_in = '0; rd_in = '0;
    mux_in = WB_ALU; pc_in = '0; uimm_in = '0;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    n_cmp++; if (bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req: got %b want 0", bus.req); end
    @(posedge clock); #1;
    bus.rvalid = 1'b0;
    n_cmp++;
    if ({wb_alu, wb_load, wb_pc, wb_uimm, wb_mux, wb_rd} !== '0) begin
      n_bad++; $display("FAIL rst_mid_wb: got %h %h %h %h %0d %0d want all 0", wb_alu, wb_load, wb_pc, wb_uimm, wb_mux, wb_rd);
    end
    run_op(1'b1, LSU_LW, 32'h3004, 32'h0, 0, 1, 32'h1357_9BDF, 5'd6, WB_LOAD, 32'h0, 32'h0,
           st, er, fr, fa, fw_e, fb, fwd, bo, hg);
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL rst_next_stalls: got %0d want 1", st); end
    n_cmp++; if (wb_load !== 32'h1357_9BDF) begin n_bad++; $display("FAIL rst_next_data: got %h want 13579bdf", wb_load); end
  endtask

  task automatic test_back_to_back();
    load_store_func_code ops[8] = '{LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
    int st, er, xs, xe, g, r, sel; logic fr, fw_e, bo, hg, en, xq;
    logic [31:0] fa, fwd, a, w, d, pc, ui, xl, xwd; logic [3:0] fb, xbe; logic [4:0] rd, xr;
    load_store_func_code op; write_back_mux_selector mux;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      en  = (sel != 8);
      op  = ops[sel % 8];
      a = $urandom; w = $urandom; d = $urandom; pc = $urandom; ui = $urandom;
      rd = 5'($urandom_range(1, 31)); mux = write_back_mux_selector'($urandom_range(0, 3));
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(1, 3);
      run_op(en, op, a, w, g, r, d, rd, mux, pc, ui, st, er, fr, fa, fw_e, fb, fwd, bo, hg);
      ref_model(en, op, a, g, r, d, rd, xs, xe, xl, xr, xq);
      n_cmp++; if (hg !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_hang: op never completed", n); end
      n_cmp++; if (st !== xs) begin n_bad++; $display("FAIL rnd%0d_stalls: got %0d want %0d", n, st, xs); end
      n_cmp++; if (er !== xe) begin n_bad++; $display("FAIL rnd%0d_bus_error: got %0d want %0d", n, er, xe); end
      n_cmp++; if (fr !== xq) begin n_bad++; $display("FAIL rnd%0d_req: got %b want %b", n, fr, xq); end
      n_cmp++; if (wb_rd !== xr) begin n_bad++; $display("FAIL rnd%0d_rd: got %0d want %0d", n, wb_rd, xr); end
      n_cmp++; if (wb_alu !== a || wb_pc !== pc || wb_uimm !== ui || wb_mux !== mux) begin
        n_bad++; $display("FAIL rnd%0d_passthru: got %h %h %h %0d want %h %h %h %0d", n, wb_alu, wb_pc, wb_uimm, wb_mux, a, pc, ui, mux);
      end
      n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_bubble: got %b want 1", n, bo); end
      if (xq) begin
        n_cmp++; if (fa !== (a & 32'hFFFF_FFFC) || fw_e !== is_store_op(op)) begin
          n_bad++; $display("FAIL rnd%0d_addr_we: got %h %b want %h %b", n, fa, fw_e, a & 32'hFFFF_FFFC, is_store_op(op));
        end
        if (is_store_op(op)) begin
          ref_store(op, a, w, xbe, xwd);
          n_cmp++; if (fb !== xbe || fwd !== xwd) begin
            n_bad++; $display("FAIL rnd%0d_store_fmt: got be=%b wd=%h want be=%b wd=%h", n, fb, fwd, xbe, xwd);
          end
        end else begin
          n_cmp++; if (wb_load !== xl) begin n_bad++; $display("FAIL rnd%0d_load: got %h want %h", n, wb_load, xl); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; lsu_enable = 1'b0; op_in = LSU_LB; alu_in = '0; wdata_in = '0;
    mux_in = WB_ALU; rd_in = '0; pc_in = '0; uimm_in = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    @(posedge clock); #1;
    test_reset();
    test_alu_passthrough();
    test_store_sb();
    test_load_format();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
